// File: rtl/uart_regbus_arbiter.sv
// Round-robin arbiter sharing the UART register port between an AXI-Lite bridge (M0)
// and an internal feeder (M1); one access in flight, req/ack handshake per master.
module uart_regbus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_aresetn,
   input  logic                  m0_req,
   input  logic                  m0_wr,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_wr,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic [ADDR_WIDTH-1:0] uart_addr,
   output logic                  uart_re,
   output logic                  uart_we,
   output logic [DATA_WIDTH-1:0] uart_wdata,
   input  logic [DATA_WIDTH-1:0] uart_rdata,
   output logic                  busy,
   output logic                  grant
);

   localparam logic [2:0] RD_LAT_CNT = 3'(RD_LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACK
   } state_t;

   state_t                  state;
   logic                    last_grant;
   logic                    lat_wr;
   logic [2:0]              cnt;

   logic                    any_req;
   logic                    pick;
   logic                    sel_wr;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   // With both requesting, the master that did not own the previous access wins.
   always_comb begin
      any_req = m0_req | m1_req;
      pick    = 1'b0;
      if (m0_req && m1_req) begin
         pick = ~last_grant;
      end else if (m1_req) begin
         pick = 1'b1;
      end
      sel_wr    = pick ? m1_wr    : m0_wr;
      sel_addr  = pick ? m1_addr  : m0_addr;
      sel_wdata = pick ? m1_wdata : m0_wdata;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_wr     <= 1'b0;
         cnt        <= '0;
         grant      <= 1'b0;
         busy       <= 1'b0;
         uart_addr  <= '0;
         uart_re    <= 1'b0;
         uart_we    <= 1'b0;
         uart_wdata <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant      <= pick;
                  busy       <= 1'b1;
                  lat_wr     <= sel_wr;
                  uart_addr  <= sel_addr;
                  uart_we    <= sel_wr;
                  uart_re    <= ~sel_wr;
                  uart_wdata <= sel_wr ? sel_wdata : '0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               uart_we    <= 1'b0;
               uart_re    <= 1'b0;
               uart_wdata <= '0;
               if (lat_wr || RD_LATENCY == 0) begin
                  uart_addr <= '0;
                  if (grant) begin
                     m1_ack <= 1'b1;
                  end else begin
                     m0_ack <= 1'b1;
                  end
                  if (!lat_wr) begin
                     if (grant) begin
                        m1_rdata <= uart_rdata;
                     end else begin
                        m0_rdata <= uart_rdata;
                     end
                  end
                  state <= ACK;
               end else begin
                  cnt   <= RD_LAT_CNT;
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               // Data is valid exactly RD_LATENCY cycles after the re strobe.
               if (cnt == 3'd1) begin
                  uart_addr <= '0;
                  if (grant) begin
                     m1_ack   <= 1'b1;
                     m1_rdata <= uart_rdata;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_rdata <= uart_rdata;
                  end
                  state <= ACK;
               end
            end
            ACK: begin
               last_grant <= grant;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_regbus_arbiter.sv
// Directed bench: an RD_LATENCY=1 and an RD_LATENCY=0 instance share stimulus;
// one of them is observed at a time through the o_* mux.
module tb_uart_regbus_arbiter;

   logic       clk = 1'b0;
   logic       aresetn;
   logic       m0_req, m0_wr, m1_req, m1_wr;
   logic [4:0] m0_addr, m1_addr;
   logic [7:0] m0_wdata, m1_wdata, uart_rdata;

   logic       d1_m0_ack, d1_m1_ack, d1_re, d1_we, d1_busy, d1_grant;
   logic [7:0] d1_m0_rdata, d1_m1_rdata, d1_wdata;
   logic [4:0] d1_addr;
   logic       d0_m0_ack, d0_m1_ack, d0_re, d0_we, d0_busy, d0_grant;
   logic [7:0] d0_m0_rdata, d0_m1_rdata, d0_wdata;
   logic [4:0] d0_addr;

   logic       use0;
   logic       o_m0_ack, o_m1_ack, o_re, o_we, o_busy, o_grant;
   logic [7:0] o_m0_rdata, o_m1_rdata, o_wdata;
   logic [4:0] o_addr;

   int         total = 0;
   int         bad = 0;
   logic [7:0] exp_rd [2];

   always #5 clk = ~clk;

   uart_regbus_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(1)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
      .uart_addr(d1_addr), .uart_re(d1_re), .uart_we(d1_we), .uart_wdata(d1_wdata),
      .uart_rdata(uart_rdata), .busy(d1_busy), .grant(d1_grant));

   uart_regbus_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .RD_LATENCY(0)) dut0 (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(d0_m0_ack), .m0_rdata(d0_m0_rdata),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(d0_m1_ack), .m1_rdata(d0_m1_rdata),
      .uart_addr(d0_addr), .uart_re(d0_re), .uart_we(d0_we), .uart_wdata(d0_wdata),
      .uart_rdata(uart_rdata), .busy(d0_busy), .grant(d0_grant));

   always_comb begin
      o_m0_ack   = use0 ? d0_m0_ack   : d1_m0_ack;
      o_m1_ack   = use0 ? d0_m1_ack   : d1_m1_ack;
      o_m0_rdata = use0 ? d0_m0_rdata : d1_m0_rdata;
      o_m1_rdata = use0 ? d0_m1_rdata : d1_m1_rdata;
      o_re       = use0 ? d0_re       : d1_re;
      o_we       = use0 ? d0_we       : d1_we;
      o_addr     = use0 ? d0_addr     : d1_addr;
      o_wdata    = use0 ? d0_wdata    : d1_wdata;
      o_busy     = use0 ? d0_busy     : d1_busy;
      o_grant    = use0 ? d0_grant    : d1_grant;
   end

   typedef struct {
      int         m;
      logic       wr;
      logic [4:0] a;
      logic [7:0] wd;
      logic [7:0] rd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      {m0_req, m0_wr, m0_addr, m0_wdata} = '0;
      {m1_req, m1_wr, m1_addr, m1_wdata} = '0;
      uart_rdata = 8'hEE;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Starts in an IDLE cycle (#1 after the edge); returns at the IDLE cycle after ACK.
   task automatic access(input int m, input logic wr, input logic [4:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input int rl, input string nm, output time t_ack);
      int ackc;
      ackc  = wr ? 2 : 2 + rl;
      t_ack = 0;
      if (m == 0) {m0_req, m0_wr, m0_addr, m0_wdata} = {1'b1, wr, a, wd};
      else        {m1_req, m1_wr, m1_addr, m1_wdata} = {1'b1, wr, a, wd};
      for (int c = 0; c <= ackc; c++) begin
         uart_rdata = (c == 1 + rl) ? rd : 8'hEE;
         @(negedge clk);
         chk({nm, " we"},    32'(o_we),    32'(wr && c == 1));
         chk({nm, " re"},    32'(o_re),    32'(!wr && c == 1));
         chk({nm, " addr"},  32'(o_addr),  32'((c >= 1 && c < ackc) ? a : 5'h00));
         chk({nm, " wdata"}, 32'(o_wdata), 32'((wr && c == 1) ? wd : 8'h00));
         chk({nm, " busy"},  32'(o_busy),  32'(c >= 1));
         if (c >= 1) chk({nm, " grant"}, 32'(o_grant), 32'(m));
         chk({nm, " m0_ack"}, 32'(o_m0_ack), 32'(c == ackc && m == 0));
         chk({nm, " m1_ack"}, 32'(o_m1_ack), 32'(c == ackc && m == 1));
         if (c == ackc && !wr) exp_rd[m] = rd;
         chk({nm, " m0_rdata"}, 32'(o_m0_rdata), 32'(exp_rd[0]));
         chk({nm, " m1_rdata"}, 32'(o_m1_rdata), 32'(exp_rd[1]));
         if (c == ackc) begin
            t_ack = $time;
            if (m == 0) m0_req = 1'b0;
            else        m1_req = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Both masters hold write requests for n accesses; three cycles per access.
   task automatic alt(input int n, input string nm);
      int k, ph, own;
      {m0_req, m0_wr, m0_addr, m0_wdata} = {1'b1, 1'b1, 5'h0A, 8'h11};
      {m1_req, m1_wr, m1_addr, m1_wdata} = {1'b1, 1'b1, 5'h0B, 8'h22};
      uart_rdata = 8'hEE;
      for (int c = 0; c < 3 * n; c++) begin
         k   = c / 3;
         ph  = c % 3;
         own = k % 2;
         @(negedge clk);
         chk({nm, " busy"}, 32'(o_busy), 32'(ph != 0));
         if (ph != 0) chk({nm, " grant"}, 32'(o_grant), 32'(own));
         chk({nm, " we"},   32'(o_we),   32'(ph == 1));
         chk({nm, " re"},   32'(o_re),   32'(0));
         chk({nm, " addr"}, 32'(o_addr), 32'((ph == 1) ? ((own == 1) ? 5'h0B : 5'h0A) : 5'h00));
         chk({nm, " m0_ack"}, 32'(o_m0_ack), 32'(ph == 2 && own == 0));
         chk({nm, " m1_ack"}, 32'(o_m1_ack), 32'(ph == 2 && own == 1));
         if (c == 3 * n - 1) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tv [6];
      time  t1, t2;
      tv[0] = '{0, 1'b1, 5'h03, 8'h83, 8'h00};
      tv[1] = '{1, 1'b0, 5'h05, 8'h00, 8'h60};
      tv[2] = '{0, 1'b0, 5'h1F, 8'h00, 8'hA5};
      tv[3] = '{1, 1'b1, 5'h1E, 8'h5A, 8'h00};
      tv[4] = '{0, 1'b1, 5'h00, 8'hFF, 8'h00};
      tv[5] = '{1, 1'b0, 5'h00, 8'h00, 8'h01};

      use0 = 1'b0;
      do_reset();
      @(negedge clk);
      chk("rst busy",   32'(o_busy),  32'(0));
      chk("rst strobe", 32'({o_re, o_we}), 32'(0));
      chk("rst addr",   32'(o_addr),  32'(0));
      chk("rst wdata",  32'(o_wdata), 32'(0));
      chk("rst acks",   32'({o_m0_ack, o_m1_ack}), 32'(0));
      chk("rst rdata",  32'({o_m0_rdata, o_m1_rdata}), 32'(0));
      chk("rst grant",  32'(o_grant), 32'(0));
      @(posedge clk);
      #1;

      alt(4, "rr");

      for (int i = 0; i < 6; i++) begin
         access(tv[i].m, tv[i].wr, tv[i].a, tv[i].wd, tv[i].rd, 1, $sformatf("vec%0d", i), t1);
      end

      // Reset while an M0 read is in WAIT.
      do_reset();
      {m0_req, m0_wr, m0_addr, m0_wdata} = {1'b1, 1'b0, 5'h07, 8'h00};
      uart_rdata = 8'hEE;
      @(posedge clk);
      #1;
      chk("abort issue re", 32'(o_re), 32'(1));
      @(posedge clk);
      #1;
      chk("abort wait busy", 32'(o_busy), 32'(1));
      chk("abort wait addr", 32'(o_addr), 32'(5'h07));
      aresetn = 1'b0;
      m0_req  = 1'b0;
      uart_rdata = 8'h99;
      #1;
      chk("abort re",   32'(o_re),     32'(0));
      chk("abort busy", 32'(o_busy),   32'(0));
      chk("abort addr", 32'(o_addr),   32'(0));
      chk("abort ack",  32'(o_m0_ack), 32'(0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("abort no ack", 32'(o_m0_ack), 32'(0));
      end
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      chk("abort post busy",  32'(o_busy),     32'(0));
      chk("abort post rdata", 32'(o_m0_rdata), 32'(0));
      alt(2, "post-abort rr");

      // RD_LATENCY = 0 instance: back-to-back M0 reads.
      use0 = 1'b1;
      do_reset();
      access(0, 1'b0, 5'h00, 8'h00, 8'h3C, 0, "rl0 a", t1);
      access(0, 1'b0, 5'h02, 8'h00, 8'hC3, 0, "rl0 b", t2);
      chk("rl0 ack spacing", 32'(t2 - t1), 32'(30));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
